pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_hazard_detect.sv | 38 +++
 rtl/pipe_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
//============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared definitions for the pipeline controller: FSM state
//               encoding and the memory-wait counter width. Also provides
//               the machine word width `XLEN when it is not already defined.
// Revision    : 1.0 - initial release
//============================================================================
`ifndef XLEN
`define XLEN 32
`endif

package pipe_ctrl_pkg;

    // Controller FSM encoding.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } pc_state_e;

    // Wide enough for the largest allowed MEM_TIMEOUT (255).
    localparam int TMO_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_detect.sv
`default_nettype none
//============================================================================
// Module      : pipe_hazard_detect
// Description : Combinational load-use hazard detector. Flags when the
//               instruction in ID reads a register that the load in EX is
//               about to write. Register 0 never creates a hazard.
// Ports       : i_id_rs1/i_id_rs2      ID source register indices
//               i_id_rs1_used/_rs2_used source actually read
//               i_ex_rd                 EX destination register
//               i_ex_is_load            EX instruction is a load
//               o_load_use              hazard present this cycle
// Revision    : 1.0 - initial release
//============================================================================
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs2,
    input  logic                      i_id_rs1_used,
    input  logic                      i_id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd,
    input  logic                      i_ex_is_load,
    output logic                      o_load_use
);

    logic w_rd_nonzero;
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rd_nonzero = |i_ex_rd;
    assign w_rs1_hit    = i_id_rs1_used && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit    = i_id_rs2_used && (i_id_rs2 == i_ex_rd);
    assign o_load_use   = i_ex_is_load && w_rd_nonzero && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
//============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hazard / stall controller. A three-state FSM
//               (RUN, MEM_WAIT, FLUSH) holds the mode; pause and flush
//               outputs decode combinationally from the state and the
//               current inputs. A memory wait that exceeds MEM_TIMEOUT
//               cycles aborts and sets a sticky mem_timeout flag.
// Ports       : clk, rst (async, active-low)
//               id_rs1/id_rs2/id_rs1_used/id_rs2_used, ex_rd, ex_is_load,
//               ex_branch_taken        hazard sources
//               mem_req, mem_ready     MEM stage handshake
//               pause_if/id/ex/mem     stage-register pauses
//               flush_id/flush_ex      bubble insertion
//               mem_timeout            sticky abort flag
//               perf_stall/perf_flush  performance counters
// Config      : PIPE_CTRL_PERF_EN - when defined, perf_stall counts cycles
//               with any pause and perf_flush counts branch flushes; when
//               undefined both ports are tied to zero.
// Revision    : 1.0 - initial release
//============================================================================
`ifndef XLEN
`define XLEN 32
`endif

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_is_load,
    input  logic                      ex_branch_taken,
    input  logic                      mem_req,
    input  logic                      mem_ready,
    output logic                      pause_if,
    output logic                      pause_id,
    output logic                      pause_ex,
    output logic                      pause_mem,
    output logic                      flush_id,
    output logic                      flush_ex,
    output logic                      mem_timeout,
    output logic [`XLEN-1:0]          perf_stall,
    output logic [`XLEN-1:0]          perf_flush
);

    localparam logic [TMO_CNT_W-1:0] c_TMO_LIMIT = TMO_CNT_W'(MEM_TIMEOUT);
    localparam logic [TMO_CNT_W-1:0] c_CNT_ONE   = TMO_CNT_W'(1);

    pc_state_e              r_state;
    pc_state_e              w_state_nxt;
    logic [TMO_CNT_W-1:0]   r_cnt;
    logic [TMO_CNT_W-1:0]   w_cnt_nxt;
    logic                   r_tmo;

    logic w_mem_stall;
    logic w_load_use;
    logic w_run_decode;
    logic w_tmo_set;
    logic w_pause_all;
    logic w_pause_front;
    logic w_flush_id;
    logic w_flush_ex;

    assign w_mem_stall = mem_req && !mem_ready;

    pipe_hazard_detect #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_hazard (
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_rs1_used (id_rs1_used),
        .i_id_rs2_used (id_rs2_used),
        .i_ex_rd       (ex_rd),
        .i_ex_is_load  (ex_is_load),
        .o_load_use    (w_load_use)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_tmo_set) begin
                r_tmo <= 1'b1;
            end
        end
    end

    // r_cnt counts paused memory-wait cycles, including the RUN cycle that
    // first saw the stall, so the abort fires after exactly MEM_TIMEOUT
    // paused cycles.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_run_decode  = 1'b0;
        w_tmo_set     = 1'b0;
        w_pause_all   = 1'b0;
        w_pause_front = 1'b0;
        w_flush_id    = 1'b0;
        w_flush_ex    = 1'b0;

        case (r_state)
            ST_RUN: begin
                w_run_decode = 1'b1;
            end
            ST_MEM_WAIT: begin
                // Branches are ignored here: EX is frozen and re-presents it.
                if (w_mem_stall) begin
                    if (r_cnt >= c_TMO_LIMIT) begin
                        // Abort: release the pipeline for this cycle only.
                        w_tmo_set   = 1'b1;
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_pause_all = 1'b1;
                        w_cnt_nxt   = r_cnt + c_CNT_ONE;
                    end
                end else begin
                    // Completion cycle behaves exactly like RUN.
                    w_run_decode = 1'b1;
                end
            end
            ST_FLUSH: begin
                // Second bubble covers the fetch redirect latency. The ID
                // instruction is being killed, so load-use is irrelevant.
                w_flush_id = 1'b1;
                if (w_mem_stall) begin
                    w_pause_all = 1'b1;
                    w_state_nxt = ST_MEM_WAIT;
                    w_cnt_nxt   = c_CNT_ONE;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase

        if (w_run_decode) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
            if (w_mem_stall) begin
                w_pause_all = 1'b1;
                w_state_nxt = ST_MEM_WAIT;
                w_cnt_nxt   = c_CNT_ONE;
            end else if (ex_branch_taken) begin
                w_flush_id  = 1'b1;
                w_flush_ex  = 1'b1;
                w_state_nxt = ST_FLUSH;
            end else if (w_load_use) begin
                w_pause_front = 1'b1;
                w_flush_ex    = 1'b1;
            end
        end
    end

    assign pause_if    = w_pause_all || w_pause_front;
    assign pause_id    = w_pause_all || w_pause_front;
    assign pause_ex    = w_pause_all;
    assign pause_mem   = w_pause_all;
    assign flush_id    = w_flush_id;
    assign flush_ex    = w_flush_ex;
    assign mem_timeout = r_tmo;

`ifdef PIPE_CTRL_PERF_EN
    logic [`XLEN-1:0] r_perf_stall;
    logic [`XLEN-1:0] r_perf_flush;
    logic             w_flush_evt;

    // FLUSH always exits after one cycle, so any cycle heading into FLUSH
    // is a fresh branch flush.
    assign w_flush_evt = (w_state_nxt == ST_FLUSH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (pause_if) begin
                r_perf_stall <= r_perf_stall + `XLEN'(1);
            end
            if (w_flush_evt) begin
                r_perf_flush <= r_perf_flush + `XLEN'(1);
            end
        end
    end

    assign perf_stall = r_perf_stall;
    assign perf_flush = r_perf_flush;
`else
    assign perf_stall = '0;
    assign perf_flush = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl: directed scenarios plus
//               randomized traffic compared against a behavioural model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_pipe_ctrl;

    localparam int RAW = 5;
    localparam int TMO = 4;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [RAW-1:0] id_rs1, id_rs2, ex_rd;
    logic           id_rs1_used, id_rs2_used, ex_is_load, ex_branch_taken;
    logic           mem_req, mem_ready;
    logic           pause_if, pause_id, pause_ex, pause_mem;
    logic           flush_id, flush_ex, mem_timeout;
    logic [31:0]    perf_stall, perf_flush;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .REG_ADDR_WIDTH (RAW),
        .MEM_TIMEOUT    (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .ex_rd           (ex_rd),
        .ex_is_load      (ex_is_load),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pause_if        (pause_if),
        .pause_id        (pause_id),
        .pause_ex        (pause_ex),
        .pause_mem       (pause_mem),
        .flush_id        (flush_id),
        .flush_ex        (flush_ex),
        .mem_timeout     (mem_timeout),
        .perf_stall      (perf_stall),
        .perf_flush      (perf_flush)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: "waiting" tracks an outstanding memory stall and how
    // many paused cycles it has used; "redirect" marks the cycle after a
    // taken branch.
    bit          m_waiting, m_redirect, m_tmo;
    int          m_waited;
    int unsigned m_nstall, m_nflush;
    bit          n_waiting, n_redirect, n_tmo;
    int          n_waited;
    int unsigned n_nstall, n_nflush;
    bit          e_pif, e_pid, e_pex, e_pmem, e_fid, e_fex;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_waiting = 0; m_redirect = 0; m_tmo = 0; m_waited = 0;
        m_nstall = 0; m_nflush = 0;
    endtask

    task automatic predict();
        bit ms, lu, hit1, hit2;
        ms   = mem_req && !mem_ready;
        hit1 = id_rs1_used && (id_rs1 == ex_rd);
        hit2 = id_rs2_used && (id_rs2 == ex_rd);
        lu   = ex_is_load && (ex_rd != 0) && (hit1 || hit2);
        {e_pif, e_pid, e_pex, e_pmem, e_fid, e_fex} = '0;
        n_waiting = 0; n_waited = 0; n_redirect = 0;
        n_tmo = m_tmo; n_nstall = m_nstall; n_nflush = m_nflush;
        if (m_waiting && ms) begin
            if (m_waited >= TMO) begin
                n_tmo = 1;
            end else begin
                {e_pif, e_pid, e_pex, e_pmem} = 4'b1111;
                n_waiting = 1;
                n_waited  = m_waited + 1;
            end
        end else begin
            e_fid = m_redirect;
            if (ms) begin
                {e_pif, e_pid, e_pex, e_pmem} = 4'b1111;
                n_waiting = 1;
                n_waited  = 1;
            end else if (!m_redirect && ex_branch_taken) begin
                e_fid = 1; e_fex = 1;
                n_redirect = 1;
                n_nflush = m_nflush + 1;
            end else if (!m_redirect && lu) begin
                e_pif = 1; e_pid = 1; e_fex = 1;
            end
        end
        if (e_pif || e_pid || e_pex || e_pmem) n_nstall = m_nstall + 1;
    endtask

    task automatic commit();
        m_waiting = n_waiting; m_waited = n_waited; m_redirect = n_redirect;
        m_tmo = n_tmo; m_nstall = n_nstall; m_nflush = n_nflush;
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, ".pause_if"},    {31'd0, pause_if},    {31'd0, e_pif});
        chk({pfx, ".pause_id"},    {31'd0, pause_id},    {31'd0, e_pid});
        chk({pfx, ".pause_ex"},    {31'd0, pause_ex},    {31'd0, e_pex});
        chk({pfx, ".pause_mem"},   {31'd0, pause_mem},   {31'd0, e_pmem});
        chk({pfx, ".flush_id"},    {31'd0, flush_id},    {31'd0, e_fid});
        chk({pfx, ".flush_ex"},    {31'd0, flush_ex},    {31'd0, e_fex});
        chk({pfx, ".mem_timeout"}, {31'd0, mem_timeout}, {31'd0, m_tmo});
        chk({pfx, ".perf_stall"},  perf_stall, PERF ? m_nstall : 32'd0);
        chk({pfx, ".perf_flush"},  perf_flush, PERF ? m_nflush : 32'd0);
    endtask

    // Inputs are set at posedge+1; outputs checked at posedge+2.
    task automatic cycle(input string pfx);
        predict();
        #1;
        check_outputs(pfx);
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
        ex_rd = '0; ex_is_load = 0; ex_branch_taken = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    // Asynchronous reset asserted mid-cycle; release on the falling edge.
    task automatic do_reset(input string pfx);
        rst = 0;
        #1;
        model_reset();
        predict();
        check_outputs(pfx);
        idle();
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    int unsigned base;

    initial begin
        rst = 0;
        idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        predict();
        check_outputs("reset");
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;

        // Load-use on rs1, then the same with x0 as destination.
        ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
        cycle("lu");
        ex_rd = 0; id_rs1 = 0;
        cycle("lu_x0");
        idle();
        cycle("lu_idle");

        // Taken branch: two-cycle flush then back to normal.
        ex_branch_taken = 1;
        cycle("br0");
        ex_branch_taken = 0;
        cycle("br1");
        cycle("br2");
        chk("br_perf_flush", perf_flush, PERF ? 32'd1 : 32'd0);

        // Memory wait: three stalled cycles then ready.
        base = m_nstall;
        mem_req = 1; mem_ready = 0;
        repeat (3) cycle("mw");
        mem_ready = 1;
        cycle("mw_ready");
        idle();
        cycle("mw_done");
        chk("mw_perf_stall", perf_stall, PERF ? base + 32'd3 : 32'd0);

        // Memory stall, branch and load-use together.
        mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
        ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_rs2_used = 1;
        cycle("sim0");
        mem_ready = 1;
        cycle("sim1");
        idle();
        cycle("sim2");
        cycle("sim3");

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            mem_req         = ($urandom_range(0, 99) < 40);
            mem_ready       = ($urandom_range(0, 99) < 70);
            ex_branch_taken = ($urandom_range(0, 99) < 15);
            ex_is_load      = ($urandom_range(0, 99) < 50);
            ex_rd           = RAW'($urandom_range(0, 3));
            id_rs1          = RAW'($urandom_range(0, 3));
            id_rs2          = RAW'($urandom_range(0, 3));
            id_rs1_used     = 1'($urandom_range(0, 1));
            id_rs2_used     = 1'($urandom_range(0, 1));
            cycle("rnd");
        end
        do_reset("rnd_rst");

        // Timeout: ready never arrives.
        mem_req = 1; mem_ready = 0;
        repeat (6) cycle("tmo");
        chk("tmo_flag", {31'd0, mem_timeout}, 32'd1);
        idle();
        repeat (3) cycle("tmo_hold");
        chk("tmo_sticky", {31'd0, mem_timeout}, 32'd1);
        do_reset("tmo_rst");
        chk("tmo_cleared", {31'd0, mem_timeout}, 32'd0);

        // Reset asserted while in FLUSH.
        ex_branch_taken = 1;
        cycle("fl0");
        ex_branch_taken = 0;
        predict();
        #1;
        check_outputs("fl1");
        do_reset("fl_rst");
        cycle("fl_after");
        chk("fl_perf_stall", perf_stall, 32'd0);
        chk("fl_perf_flush", perf_flush, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
